nor_bus_cycle_engine: RTL and testbench

Single-transaction bus-cycle engine for the parallel NOR flash on the Nexys3 board. It sits directly downstream of the NOR command sequencers: it accepts one write, read or status-poll request at a time and drives CE/WE/OE/ADDR/DATA with cycle-exact, parameterised timing. Sequencers therefore issue abstract operations instead of hand-stepping strobes through idle states. It returns read data or final status, plus an error flag, through a one-cycle response pulse.

---
 rtl/nor_pkg.sv | 36 +++
 rtl/nor_delay_cnt.sv | 26 ++
 rtl/nor_bus_cycle_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_nor_bus_cycle_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nor_pkg.sv
// Shared definitions for the NOR flash bus-cycle engine: op encodings, FSM states,
// flash command words and status-register bit positions.
package nor_pkg;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_POLL    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_PULSE,
        WR_HOLD,
        RD_WAIT,
        RD_SAMPLE,
        RECOVER,
        RESP
    } state_e;

    localparam logic [15:0] CMD_BLOCK_LOCK_SETUP = 16'h0060;
    localparam logic [15:0] CMD_CONFIRM          = 16'h00D0;
    localparam logic [15:0] CMD_READ_ID          = 16'h0090;
    localparam logic [15:0] CMD_ERASE_SETUP      = 16'h0020;
    localparam logic [15:0] CMD_CLEAR_STATUS     = 16'h0050;
    localparam logic [15:0] CMD_READ_STATUS      = 16'h0070;
    localparam logic [15:0] CMD_PROGRAM          = 16'h0040;

    localparam int SR_READY_BIT = 7;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nor_delay_cnt.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module nor_delay_cnt #(
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/nor_bus_cycle_engine.sv
// Single-transaction write/read/status-poll engine driving the NOR flash strobes.
// Define NOR_POLL_TIMEOUT_EN to bound status polling to POLL_MAX_READS reads.
module nor_bus_cycle_engine
    import nor_pkg::*;
#(
    parameter int T_WP           = 3,
    parameter int T_RD           = 4,
    parameter int T_REC          = 1,
    parameter int POLL_MAX_READS = 20000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [23:0] REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        CE,
    output logic        WE,
    output logic        OE,
    output logic [23:0] ADDR,
    inout  wire  [15:0] DATA
);

    localparam int CNT_W = $clog2(maxOf3(T_WP, T_RD, T_REC) + 1);
    localparam logic [CNT_W-1:0] WP_LOAD  = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'((T_RD > 1) ? T_RD - 2 : 0);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(T_REC - 1);
    // RD_SAMPLE is always the last OE-low cycle, so a one-cycle read skips RD_WAIT.
    localparam state_e RD_ENTRY = (T_RD > 1) ? RD_WAIT : RD_SAMPLE;

    if (T_WP < 1 || T_RD < 1 || T_REC < 1 || POLL_MAX_READS < 1) begin : g_badParams
        $error("nor_bus_cycle_engine: timing parameters and POLL_MAX_READS must be >= 1");
    end

    state_e      r_state, w_stateNxt;
    logic [1:0]  r_op, w_opNxt;
    logic [23:0] r_addr, w_addrNxt;
    logic [15:0] r_wdata, w_wdataNxt;
    logic [15:0] r_rspRdata, w_rspRdataNxt;
    logic        r_drv, w_drvNxt;
    logic        r_ce, w_ceNxt;
    logic        r_we, w_weNxt;
    logic        r_oe, w_oeNxt;
    logic        r_rspErr, w_rspErrNxt;
    logic        r_pollRead, w_pollReadNxt;
    logic        w_cntLoad;
    logic [CNT_W-1:0] w_cntValue;
    logic        w_cntZero;
    logic        w_timeout;
    logic        w_pollMore;
    logic        w_pollCntInc;
    logic        w_pollCntClr;

    nor_delay_cnt #(.W(CNT_W)) u_delay (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_load  (w_cntLoad),
        .i_value (w_cntValue),
        .o_zero  (w_cntZero)
    );

`ifdef NOR_POLL_TIMEOUT_EN
    localparam int PC_W = $clog2(POLL_MAX_READS + 1);
    logic [PC_W-1:0] r_pollCnt;

    always_ff @(posedge CLK) begin
        if (RESET || w_pollCntClr) begin
            r_pollCnt <= '0;
        end else if (w_pollCntInc) begin
            r_pollCnt <= r_pollCnt + 1'b1;
        end
    end

    assign w_timeout = (r_pollCnt == PC_W'(POLL_MAX_READS));
`else
    assign w_timeout = 1'b0;
`endif

    // Poll keeps reading until the ready bit shows up (or the read budget runs out).
    assign w_pollMore = (r_op == OP_POLL) &&
                        (!r_pollRead || (!r_rspRdata[SR_READY_BIT] && !w_timeout));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_op       <= OP_WRITE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rspRdata <= '0;
            r_drv      <= 1'b0;
            r_ce       <= 1'b1;
            r_we       <= 1'b1;
            r_oe       <= 1'b1;
            r_rspErr   <= 1'b0;
            r_pollRead <= 1'b0;
        end else begin
            r_state    <= w_stateNxt;
            r_op       <= w_opNxt;
            r_addr     <= w_addrNxt;
            r_wdata    <= w_wdataNxt;
            r_rspRdata <= w_rspRdataNxt;
            r_drv      <= w_drvNxt;
            r_ce       <= w_ceNxt;
            r_we       <= w_weNxt;
            r_oe       <= w_oeNxt;
            r_rspErr   <= w_rspErrNxt;
            r_pollRead <= w_pollReadNxt;
        end
    end

    always_comb begin
        w_stateNxt     = r_state;
        w_opNxt        = r_op;
        w_addrNxt      = r_addr;
        w_wdataNxt     = r_wdata;
        w_rspRdataNxt  = r_rspRdata;
        w_drvNxt       = r_drv;
        w_ceNxt        = r_ce;
        w_weNxt        = r_we;
        w_oeNxt        = r_oe;
        w_rspErrNxt    = r_rspErr;
        w_pollReadNxt  = r_pollRead;
        w_cntLoad      = 1'b0;
        w_cntValue     = '0;
        w_pollCntInc   = 1'b0;
        w_pollCntClr   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (REQ_VALID) begin
                    w_opNxt       = REQ_OP;
                    w_addrNxt     = REQ_ADDR;
                    w_rspErrNxt   = 1'b0;
                    w_pollReadNxt = 1'b0;
                    w_pollCntClr  = 1'b1;
                    if (REQ_OP == OP_WRITE || REQ_OP == OP_POLL) begin
                        w_wdataNxt = (REQ_OP == OP_POLL) ? CMD_READ_STATUS : REQ_WDATA;
                        w_drvNxt   = 1'b1;
                        w_ceNxt    = 1'b0;
                        w_weNxt    = 1'b0;
                        w_cntLoad  = 1'b1;
                        w_cntValue = WP_LOAD;
                        w_stateNxt = WR_PULSE;
                    end else if (REQ_OP == OP_READ) begin
                        w_ceNxt    = 1'b0;
                        w_oeNxt    = 1'b0;
                        w_cntLoad  = 1'b1;
                        w_cntValue = RD_LOAD;
                        w_stateNxt = RD_ENTRY;
                    end else begin
                        w_rspErrNxt = 1'b1;
                        w_stateNxt  = RESP;
                    end
                end
            end
            WR_PULSE: begin
                if (w_cntZero) begin
                    w_ceNxt    = 1'b1;
                    w_weNxt    = 1'b1;
                    w_stateNxt = WR_HOLD;
                end
            end
            WR_HOLD: begin
                w_drvNxt   = 1'b0;
                w_cntLoad  = 1'b1;
                w_cntValue = REC_LOAD;
                w_stateNxt = RECOVER;
            end
            RD_WAIT: begin
                if (w_cntZero) begin
                    w_stateNxt = RD_SAMPLE;
                end
            end
            RD_SAMPLE: begin
                w_rspRdataNxt = DATA;
                w_ceNxt       = 1'b1;
                w_oeNxt       = 1'b1;
                w_pollCntInc  = (r_op == OP_POLL);
                w_cntLoad     = 1'b1;
                w_cntValue    = REC_LOAD;
                w_stateNxt    = RECOVER;
            end
            RECOVER: begin
                if (w_cntZero) begin
                    if (w_pollMore) begin
                        w_ceNxt       = 1'b0;
                        w_oeNxt       = 1'b0;
                        w_pollReadNxt = 1'b1;
                        w_cntLoad     = 1'b1;
                        w_cntValue    = RD_LOAD;
                        w_stateNxt    = RD_ENTRY;
                    end else begin
                        w_rspErrNxt = (r_op == OP_POLL) && !r_rspRdata[SR_READY_BIT];
                        w_stateNxt  = RESP;
                    end
                end
            end
            RESP: begin
                w_stateNxt = IDLE;
            end
            default: begin
                w_stateNxt = IDLE;
            end
        endcase
    end

    assign REQ_READY = (r_state == IDLE);
    assign RSP_VALID = (r_state == RESP);
    assign RSP_RDATA = r_rspRdata;
    assign RSP_ERR   = r_rspErr;
    assign CE        = r_ce;
    assign WE        = r_we;
    assign OE        = r_oe;
    assign ADDR      = r_addr;
    assign DATA      = r_drv ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_nor_bus_cycle_engine.sv
// Directed bench for nor_bus_cycle_engine with a small NOR flash model on the DATA bus.
// Build with NOR_POLL_TIMEOUT_EN defined to also exercise the poll read budget.
module tb_nor_bus_cycle_engine;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [1:0]  REQ_OP = 2'b00;
    logic [23:0] REQ_ADDR = '0;
    logic [15:0] REQ_WDATA = '0;
    logic        RSP_VALID;
    logic [15:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        CE, WE, OE;
    logic [23:0] ADDR;
    wire  [15:0] DATA;

    logic [15:0] tbData = 16'h0000;
    logic [15:0] statusQ[$];

    int total = 0;
    int bad = 0;

    int weLow, oeLow, strobeCyc, wrCount, rdCount;
    logic [15:0] lastWrData, holdData;
    logic [23:0] wrAddr;
    logic        prevWe = 1'b1;

    always #5 CLK = ~CLK;

    nor_bus_cycle_engine #(
        .T_WP(3), .T_RD(4), .T_REC(1), .POLL_MAX_READS(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .CE(CE), .WE(WE), .OE(OE), .ADDR(ADDR), .DATA(DATA)
    );

    // Flash model: drives the bus while OE is low, presenting the next queued status word.
    assign DATA = (OE === 1'b0) ? tbData : 16'hzzzz;

    always @(negedge OE) begin
        rdCount++;
        if (statusQ.size() > 0) tbData = statusQ.pop_front();
    end

    always @(negedge CLK) begin
        if (WE === 1'b0) begin
            weLow++;
            lastWrData = DATA;
            wrAddr = ADDR;
            if (prevWe === 1'b1) wrCount++;
        end
        if (WE === 1'b1 && prevWe === 1'b0) holdData = DATA;
        if (OE === 1'b0) oeLow++;
        if (CE !== 1'b1 || WE !== 1'b1 || OE !== 1'b1) strobeCyc++;
        prevWe = WE;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // A released bus reads as Z in 4-state simulators and as 0 in 2-state ones.
    function automatic logic [15:0] busView(input logic [15:0] v);
        return (v === 16'hzzzz) ? 16'h0000 : v;
    endfunction

    task automatic clearMonitors();
        weLow = 0; oeLow = 0; strobeCyc = 0; wrCount = 0; rdCount = 0;
        lastWrData = '0; holdData = '0; wrAddr = '0;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [23:0] addr,
                                 input logic [15:0] wdata, output int lat);
        int guard;
        @(negedge CLK);
        clearMonitors();
        REQ_OP = op; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_VALID = 1'b1;
        guard = 0;
        while (REQ_READY !== 1'b1 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0; REQ_OP = ~op; REQ_ADDR = ~addr; REQ_WDATA = ~wdata;
        lat = 0;
        while (lat < 200) begin
            @(negedge CLK);
            if (RSP_VALID === 1'b1) break;
            lat++;
        end
        if (lat >= 200) checkOutput("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int sawRsp;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rst_ce", {31'd0, CE}, 32'd1);
        checkOutput("rst_we", {31'd0, WE}, 32'd1);
        checkOutput("rst_oe", {31'd0, OE}, 32'd1);
        checkOutput("rst_addr", {8'd0, ADDR}, 32'd0);
        checkOutput("rst_ready", {31'd0, REQ_READY}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
        checkOutput("rst_rdata", {16'd0, RSP_RDATA}, 32'd0);
        checkOutput("rst_err", {31'd0, RSP_ERR}, 32'd0);

        applyStimulus(2'b11, 24'h000123, 16'h1234, lat);
        checkOutput("ill_latency", lat, 0);
        checkOutput("ill_err", {31'd0, RSP_ERR}, 32'd1);
        checkOutput("ill_strobes", strobeCyc, 0);

        applyStimulus(2'b00, 24'h3F0000, 16'h0060, lat);
        checkOutput("wr_latency", lat, 5);
        checkOutput("wr_we_low", weLow, 3);
        checkOutput("wr_oe_low", oeLow, 0);
        checkOutput("wr_data", {16'd0, lastWrData}, 32'h0060);
        checkOutput("wr_hold_data", {16'd0, holdData}, 32'h0060);
        checkOutput("wr_addr", {8'd0, wrAddr}, 32'h3F0000);
        checkOutput("wr_err", {31'd0, RSP_ERR}, 32'd0);
        checkOutput("wr_rdata_kept", {16'd0, RSP_RDATA}, 32'd0);

        statusQ = '{16'h0089};
        applyStimulus(2'b01, 24'h3F0002, 16'hBEEF, lat);
        checkOutput("rd_latency", lat, 5);
        checkOutput("rd_oe_low", oeLow, 4);
        checkOutput("rd_we_low", weLow, 0);
        checkOutput("rd_rdata", {16'd0, RSP_RDATA}, 32'h0089);
        checkOutput("rd_err", {31'd0, RSP_ERR}, 32'd0);
        checkOutput("rd_addr", {8'd0, ADDR}, 32'h3F0002);

        statusQ = '{16'h0000, 16'h0000, 16'h0080};
        applyStimulus(2'b10, 24'h3F0004, 16'h5555, lat);
        checkOutput("poll_latency", lat, 20);
        checkOutput("poll_writes", wrCount, 1);
        checkOutput("poll_cmd", {16'd0, lastWrData}, 32'h0070);
        checkOutput("poll_wr_addr", {8'd0, wrAddr}, 32'h3F0004);
        checkOutput("poll_reads", rdCount, 3);
        checkOutput("poll_rdata", {16'd0, RSP_RDATA}, 32'h0080);
        checkOutput("poll_err", {31'd0, RSP_ERR}, 32'd0);
        @(negedge CLK);
        checkOutput("poll_rsp_one_cycle", {31'd0, RSP_VALID}, 32'd0);
        checkOutput("poll_rdata_held", {16'd0, RSP_RDATA}, 32'h0080);
        checkOutput("poll_bus_released", {16'd0, busView(DATA)}, 32'd0);

`ifdef NOR_POLL_TIMEOUT_EN
        statusQ = '{};
        tbData = 16'h0000;
        applyStimulus(2'b10, 24'h000010, 16'h0000, lat);
        checkOutput("to_reads", rdCount, 8);
        checkOutput("to_latency", lat, 45);
        checkOutput("to_err", {31'd0, RSP_ERR}, 32'd1);
        checkOutput("to_rdata", {16'd0, RSP_RDATA}, 32'h0000);
`endif

        // Reset lands in the second WE-low cycle of a write.
        @(negedge CLK);
        REQ_OP = 2'b00; REQ_ADDR = 24'h000200; REQ_WDATA = 16'h0060; REQ_VALID = 1'b1;
        while (REQ_READY !== 1'b1) @(negedge CLK);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("rst_mid_we_low", {31'd0, WE}, 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rst_mid_ce", {31'd0, CE}, 32'd1);
        checkOutput("rst_mid_we", {31'd0, WE}, 32'd1);
        checkOutput("rst_mid_oe", {31'd0, OE}, 32'd1);
        checkOutput("rst_mid_ready", {31'd0, REQ_READY}, 32'd1);
        checkOutput("rst_mid_bus", {16'd0, busView(DATA)}, 32'd0);
        sawRsp = 0;
        repeat (10) begin
            if (RSP_VALID === 1'b1) sawRsp++;
            @(negedge CLK);
        end
        checkOutput("rst_mid_no_rsp", sawRsp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
